// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between a buffered echo path and a valid/ready
// message source, issuing a one-cycle start pulse per frame and following tx_ready.
module uart_tx_arbiter #(
  parameter int ECHO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SW,
  input  logic       rx_valid,
  input  logic [7:0] rx_word,
  input  logic       msg_valid,
  input  logic [7:0] msg_word,
  output logic       msg_ready,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_word,
  output logic [7:0] word,
  output logic       grant_src,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(ECHO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH
  } state_t;

  state_t state_reg, state_next;

  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic [7:0]  fifo_mem [ECHO_DEPTH];
  logic [7:0]  word_reg;
  logic        grant_src_reg;
  logic        overflow_reg;

  logic        fifo_empty, fifo_full;
  logic        echo_req, msg_req, pick_msg, grant;
  logic        pop, push, drop;
  logic [7:0]  fifo_head, grant_byte;

  // Extra pointer MSB separates the full and empty cases when the low bits match.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr_reg[AW-1:0]];

  assign echo_req = !fifo_empty;
  assign msg_req  = SW && msg_valid;
  // On a tie the source not served last wins; grant_src starts at echo.
  assign pick_msg = msg_req && (!echo_req || !grant_src_reg);
  assign grant    = (state_reg == IDLE) && tx_ready && (echo_req || msg_req);

  assign pop        = grant && !pick_msg;
  assign push       = rx_valid && (!fifo_full || pop);
  assign drop       = rx_valid && fifo_full && !pop;
  assign grant_byte = pick_msg ? msg_word : fifo_head;

  assign msg_ready = rst && grant && pick_msg;
  assign tx_start  = (state_reg == ISSUE);
  assign busy      = (state_reg != IDLE);
  assign tx_word   = word_reg;
  assign word      = word_reg;
  assign grant_src = grant_src_reg;
  assign overflow  = overflow_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (grant) state_next = ISSUE;
      ISSUE:     state_next = WAIT_LOW;
      WAIT_LOW:  if (!tx_ready) state_next = WAIT_HIGH;
      WAIT_HIGH: if (tx_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      word_reg      <= 8'h00;
      grant_src_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      if (grant) begin
        word_reg      <= grant_byte;
        grant_src_reg <= pick_msg;
      end
      if (drop) overflow_reg <= 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= rx_word;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple transmitter model
// that drops tx_ready after each start pulse.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       SW;
  logic       rx_valid;
  logic [7:0] rx_word;
  logic       msg_valid;
  logic [7:0] msg_word;
  logic       msg_ready;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_word;
  logic [7:0] word;
  logic       grant_src;
  logic       busy;
  logic       overflow;

  logic model_en = 1'b0;
  logic force_ready = 1'b1;
  logic model_ready = 1'b1;
  int   low_cnt = 0;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int last_rx_cyc = 0;

  logic [7:0] msg_q[$];
  logic [7:0] sent_q[$];
  logic       sent_src_q[$];
  int         sent_cyc_q[$];
  logic hs = 1'b0;
  logic prev_start = 1'b0;
  int hs_count = 0, hs_cyc = -10, rdy_high_count = 0, rdy_busy_bad = 0;
  int lat_bad = 0, dbl_start = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_ready = model_en ? model_ready : force_ready;

  uart_tx_arbiter #(.ECHO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .SW(SW),
    .rx_valid(rx_valid), .rx_word(rx_word),
    .msg_valid(msg_valid), .msg_word(msg_word), .msg_ready(msg_ready),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_word(tx_word),
    .word(word), .grant_src(grant_src), .busy(busy), .overflow(overflow)
  );

  // Monitor and transmitter model, evaluated mid-cycle.
  always @(negedge clk) begin
    hs = msg_valid && msg_ready;
    if (hs) begin
      hs_count++;
      hs_cyc = cyc;
    end
    if (msg_ready) begin
      rdy_high_count++;
      if (busy) rdy_busy_bad++;
    end
    if (tx_start) begin
      sent_q.push_back(tx_word);
      sent_src_q.push_back(grant_src);
      sent_cyc_q.push_back(cyc);
      $display("frame: cycle %0d byte %h src %0d", cyc, tx_word, grant_src);
      if (grant_src && hs_cyc != cyc - 1) lat_bad++;
      if (prev_start) dbl_start++;
    end
    prev_start = tx_start;
    if (!model_en) begin
      model_ready = 1'b1;
      low_cnt = 0;
    end else if (tx_start) begin
      model_ready = 1'b0;
      low_cnt = 3;
    end else if (low_cnt > 0) begin
      low_cnt--;
      if (low_cnt == 0) model_ready = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (hs && msg_q.size() > 0) void'(msg_q.pop_front());
    msg_valid = (msg_q.size() > 0);
    if (msg_valid) msg_word = msg_q[0];
    else msg_word = 8'h00;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    step();
    rx_valid = 1'b1;
    rx_word = b;
    last_rx_cyc = cyc;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    msg_q.delete();
    msg_valid = 1'b0;
    rx_valid = 1'b0;
    model_en = 1'b0;
    force_ready = 1'b1;
    run(2);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; SW = 1'b1; rx_valid = 1'b0; rx_word = 8'h00;
    msg_valid = 1'b0; msg_word = 8'h00;
    msg_q.push_back(8'h55);
    run(3);
    total++; if (msg_valid !== 1'b1) $display("FAIL reset_msg_valid_setup: got %b expected 1", msg_valid); else passed++;
    total++; if (msg_ready !== 1'b0) $display("FAIL reset_msg_ready: got %b expected 0", msg_ready); else passed++;
    total++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b expected 0", tx_start); else passed++;
    total++; if (tx_word !== 8'h00) $display("FAIL reset_tx_word: got %h expected 00", tx_word); else passed++;
    total++; if (word !== 8'h00) $display("FAIL reset_word: got %h expected 00", word); else passed++;
    total++; if (grant_src !== 1'b0) $display("FAIL reset_grant_src: got %b expected 0", grant_src); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else passed++;
    msg_q.delete();
    msg_valid = 1'b0;
    step();
    rst = 1'b1;
    run(3);
    total++; if (busy !== 1'b0) $display("FAIL reset_idle_after_release: busy got %b expected 0", busy); else passed++;
  endtask

  task automatic test_echo_single();
    int base;
    do_reset();
    SW = 1'b0; model_en = 1'b1;
    base = sent_q.size();
    rx_pulse(8'h41);
    run(20);
    total++; if (sent_q.size() - base !== 1) $display("FAIL echo_frame_count: got %0d expected 1", sent_q.size() - base); else passed++;
    if (sent_q.size() > base) begin
      total++; if (sent_q[base] !== 8'h41) $display("FAIL echo_byte: got %h expected 41", sent_q[base]); else passed++;
      total++; if (sent_cyc_q[base] !== last_rx_cyc + 2) $display("FAIL echo_latency: got cycle %0d expected %0d", sent_cyc_q[base], last_rx_cyc + 2); else passed++;
    end
    total++; if (tx_word !== 8'h41) $display("FAIL echo_tx_word: got %h expected 41", tx_word); else passed++;
    total++; if (word !== 8'h41) $display("FAIL echo_word: got %h expected 41", word); else passed++;
    total++; if (grant_src !== 1'b0) $display("FAIL echo_grant_src: got %b expected 0", grant_src); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL echo_busy_end: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_msg();
    int base, hs0;
    do_reset();
    SW = 1'b1; model_en = 1'b1;
    base = sent_q.size();
    hs0 = hs_count;
    msg_q.push_back(8'h48);
    msg_q.push_back(8'h69);
    run(30);
    total++; if (sent_q.size() - base !== 2) $display("FAIL msg_frame_count: got %0d expected 2", sent_q.size() - base); else passed++;
    if (sent_q.size() - base >= 2) begin
      total++; if (sent_q[base] !== 8'h48) $display("FAIL msg_byte0: got %h expected 48", sent_q[base]); else passed++;
      total++; if (sent_q[base+1] !== 8'h69) $display("FAIL msg_byte1: got %h expected 69", sent_q[base+1]); else passed++;
      total++; if (sent_src_q[base+1] !== 1'b1) $display("FAIL msg_src: got %b expected 1", sent_src_q[base+1]); else passed++;
    end
    total++; if (hs_count - hs0 !== 2) $display("FAIL msg_handshakes: got %0d expected 2", hs_count - hs0); else passed++;
    total++; if (msg_valid !== 1'b0) $display("FAIL msg_drained: msg_valid got %b expected 0", msg_valid); else passed++;
  endtask

  task automatic test_tie();
    int base;
    logic [7:0] exp_b [6];
    logic       exp_s [6];
    exp_b = '{8'h48, 8'h31, 8'h49, 8'h32, 8'h4A, 8'h33};
    exp_s = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    SW = 1'b1; force_ready = 1'b0;
    base = sent_q.size();
    msg_q.push_back(8'h48);
    msg_q.push_back(8'h49);
    msg_q.push_back(8'h4A);
    rx_pulse(8'h31);
    rx_pulse(8'h32);
    rx_pulse(8'h33);
    total++; if (sent_q.size() !== base) $display("FAIL tie_no_frame_while_held: got %0d frames expected 0", sent_q.size() - base); else passed++;
    model_en = 1'b1;
    run(50);
    total++; if (sent_q.size() - base !== 6) $display("FAIL tie_frame_count: got %0d expected 6", sent_q.size() - base); else passed++;
    for (int i = 0; i < 6; i++) begin
      if (base + i < sent_q.size()) begin
        total++;
        if (sent_q[base+i] !== exp_b[i] || sent_src_q[base+i] !== exp_s[i])
          $display("FAIL tie_order[%0d]: got %h/src %0d expected %h/src %0d", i, sent_q[base+i], sent_src_q[base+i], exp_b[i], exp_s[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_sw_off();
    int base, rdy0, hs0;
    do_reset();
    SW = 1'b0; model_en = 1'b1;
    base = sent_q.size();
    rdy0 = rdy_high_count;
    hs0 = hs_count;
    msg_q.push_back(8'h70);
    rx_pulse(8'h61);
    rx_pulse(8'h62);
    run(30);
    total++; if (sent_q.size() - base !== 2) $display("FAIL swoff_frame_count: got %0d expected 2", sent_q.size() - base); else passed++;
    if (sent_q.size() - base >= 2) begin
      total++; if (sent_q[base] !== 8'h61 || sent_q[base+1] !== 8'h62) $display("FAIL swoff_bytes: got %h %h expected 61 62", sent_q[base], sent_q[base+1]); else passed++;
    end
    total++; if (rdy_high_count - rdy0 !== 0) $display("FAIL swoff_msg_ready: got %0d high cycles expected 0", rdy_high_count - rdy0); else passed++;
    total++; if (hs_count - hs0 !== 0) $display("FAIL swoff_handshake: got %0d expected 0", hs_count - hs0); else passed++;
    msg_q.delete();
    msg_valid = 1'b0;
  endtask

  task automatic test_overflow();
    int base;
    logic [7:0] b;
    do_reset();
    SW = 1'b0; force_ready = 1'b0;
    base = sent_q.size();
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      rx_pulse(b);
    end
    total++; if (overflow !== 1'b0) $display("FAIL ovf_at_full: got %b expected 0", overflow); else passed++;
    rx_pulse(8'h05);
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", overflow); else passed++;
    total++; if (sent_q.size() !== base) $display("FAIL ovf_no_frame_held: got %0d frames expected 0", sent_q.size() - base); else passed++;
    model_en = 1'b1;
    run(50);
    total++; if (sent_q.size() - base !== 4) $display("FAIL ovf_frame_count: got %0d expected 4", sent_q.size() - base); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (base + i < sent_q.size()) begin
        b = 8'(i + 1);
        total++; if (sent_q[base+i] !== b) $display("FAIL ovf_byte[%0d]: got %h expected %h", i, sent_q[base+i], b); else passed++;
      end
    end
    total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else passed++;
  endtask

  task automatic test_async_reset();
    int base, n;
    SW = 1'b0; model_en = 1'b0; force_ready = 1'b0;
    rx_pulse(8'h11);
    rx_pulse(8'h12);
    rx_pulse(8'h13);
    base = sent_q.size();
    model_en = 1'b1;
    n = 0;
    while (sent_q.size() == base && n < 20) begin
      step();
      n++;
    end
    total++; if (sent_q.size() == base) $display("FAIL arst_frame_timeout: got no frame expected one within 20 cycles"); else passed++;
    step();
    total++; if (busy !== 1'b1 || tx_ready !== 1'b0) $display("FAIL arst_wait_high_setup: busy %b tx_ready %b expected 1 0", busy, tx_ready); else passed++;
    #2;
    rst = 1'b0;
    #1;
    total++; if (tx_start !== 1'b0) $display("FAIL arst_tx_start: got %b expected 0", tx_start); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b expected 0", busy); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL arst_overflow: got %b expected 0", overflow); else passed++;
    total++; if (word !== 8'h00) $display("FAIL arst_word: got %h expected 00", word); else passed++;
    total++; if (tx_word !== 8'h00) $display("FAIL arst_tx_word: got %h expected 00", tx_word); else passed++;
    model_en = 1'b0; force_ready = 1'b1;
    run(2);
    rst = 1'b1;
    model_en = 1'b1;
    run(20);
    total++; if (sent_q.size() - base !== 1) $display("FAIL arst_fifo_flushed: got %0d frames expected 1", sent_q.size() - base); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL arst_idle_after: busy got %b expected 0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_echo_single();
    test_msg();
    test_tie();
    test_sw_off();
    test_overflow();
    test_async_reset();
    total++; if (rdy_busy_bad !== 0) $display("FAIL msg_ready_outside_idle: got %0d cycles expected 0", rdy_busy_bad); else passed++;
    total++; if (lat_bad !== 0) $display("FAIL msg_start_latency: got %0d late frames expected 0", lat_bad); else passed++;
    total++; if (dbl_start !== 0) $display("FAIL tx_start_width: got %0d long pulses expected 0", dbl_start); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between two byte sources: the echo path (bytes from the UART receiver) and the message generator. Echo bytes cannot be stalled, so they are buffered in a small FIFO. Message bytes use a valid/ready handshake. The block sequences each transmitter frame with a one-cycle start pulse and tracks the transmitter's ready line until the frame completes. It sits between receiver/message generator and the transmitter in the top-level mode logic.

## Interface
- ECHO_DEPTH, 4, echo FIFO depth in bytes; power of two, >= 2
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- SW  in  1  mode switch: 1 = message source enabled, 0 = echo only
- rx_valid  in  1  one-cycle pulse: rx_word holds a received byte
- rx_word  in  8  received byte
- msg_valid  in  1  message generator has a byte on msg_word
- msg_word  in  8  message byte
- msg_ready  out  1  arbiter accepts msg_word this cycle
- tx_ready  in  1  transmitter idle (transmit_ready)
- tx_start  out  1  one-cycle pulse: transmitter loads tx_word
- tx_word  out  8  byte to transmit
- word  out  8  last byte issued to transmitter
- grant_src  out  1  source of current/last frame: 0 echo, 1 message
- busy  out  1  frame in progress (state != IDLE)
- overflow  out  1  sticky: an echo byte was dropped

## Operation
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- IDLE: if tx_ready=1 and a request exists, grant, latch the byte into tx_word/word, set grant_src, go to ISSUE. Otherwise stay.
- Requests: echo = FIFO non-empty; message = SW=1 and msg_valid=1.
- Arbitration: if only one source requests, that source wins. If both request, round-robin against last grant_src: the source not served last wins. After reset, echo counts as the last served source, so the message source wins the first tie.
- Echo grant pops the FIFO head in the same cycle.
- Message grant: msg_ready=1 combinationally (IDLE, tx_ready=1, message wins). The transfer is msg_valid&msg_ready.
- msg_ready=0 in every other state and whenever SW=0.
- ISSUE: tx_start=1 for exactly this cycle, then go to WAIT_LOW.
- WAIT_LOW: wait for tx_ready=0, then go to WAIT_HIGH.
- WAIT_HIGH: wait for tx_ready=1, then go to IDLE.
- Back-to-back frames: IDLE may grant on the cycle it is re-entered.
- FIFO push: rx_valid=1 and (not full, or a pop in the same cycle). Data is written at the tail.
- FIFO full, rx_valid=1, no pop: the byte is dropped and overflow is set. Only reset clears overflow.
- Pointers are log2(ECHO_DEPTH)+1 bits wide and wrap modulo 2*ECHO_DEPTH. The extra MSB distinguishes full from empty.
- SW change mid-frame: the current frame completes. The new SW applies at the next arbitration.
- Pending echo bytes are always sent regardless of SW.
- Reset (asynchronous, mid-frame included): go to IDLE and empty the FIFO. All outputs 0: tx_start, tx_word, word, grant_src, busy, overflow. msg_ready is 0 during reset.

## Timing
- rx_valid at cycle N, FIFO previously empty, state IDLE, tx_ready=1: grant at N+1, tx_start=1 at N+2.
- Message: handshake at cycle M, tx_start=1 at M+1.
- tx_word and word are stable from ISSUE until the next grant.
- Minimum frame occupancy is 4 cycles: ISSUE, WAIT_LOW, WAIT_HIGH, IDLE. The exact length follows tx_ready.
- busy=1 from ISSUE through WAIT_HIGH inclusive.
- No timeout: if tx_ready never falls, the block stays in WAIT_LOW.

## Test plan
- After reset, SW=0, rx_valid with 0x41, tx_ready model drops 1 cycle after tx_start for 20 cycles -> tx_start once, 2 cycles after rx_valid; tx_word=word=0x41; grant_src=0; busy 0 after tx_ready returns.
- SW=1, msg_valid held with 0x48, 0x69 in turn, no echo traffic -> two frames in order; msg_ready pulses once per byte, only in IDLE.
- SW=1, echo 0x31 and message 0x48 both pending at reset release -> order 0x48, 0x31, then alternating while both sources stay busy.
- SW=0, msg_valid=1 held, echo bytes 0x61, 0x62 -> only 0x61, 0x62 sent; msg_ready never 1.
- Hold tx_ready=0, send ECHO_DEPTH+1 rx_valid pulses (0x01..0x05) -> FIFO holds 0x01..0x04 and overflow=1. Release tx_ready -> 0x01..0x04 sent in order; overflow stays 1.
- Assert rst in WAIT_HIGH with 2 bytes queued -> tx_start, busy, overflow, word all 0 immediately. After release, no frames until new input.
